// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and line-level constants for the TX/RX path.
//  Revision    : 1.0 - initial release
// ============================================================================

package uart_pkg;

    // PARITY is only reachable when the serializer is built with parity enabled.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_serializer_if
//  Description : Fifo read port plus serial line / status of the UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================

interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic                 fifo_ready_i;
    logic [DATA_BITS-1:0] fifo_data_i;
    logic                 fifo_read_o;
    logic                 tx_o;
    logic                 busy_o;

    // master: the fifo / system side; slave: the serializer.
    modport master (
        output fifo_ready_i,
        output fifo_data_i,
        input  fifo_read_o,
        input  tx_o,
        input  busy_o
    );

    modport slave (
        input  fifo_ready_i,
        input  fifo_data_i,
        output fifo_read_o,
        output tx_o,
        output busy_o
    );
endinterface

`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_counter
//  Description : Bit-period divider; bit_done pulses on the last cycle of a bit.
//  Revision    : 1.0 - initial release
// ============================================================================

module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 104
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic clear,
    output logic      bit_done
);

    localparam int             CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_param_check
            $error("uart_baud_counter: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    // Not gated by clear: the serializer needs the pulse on the same cycle it pops.
    assign bit_done = (r_count == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_serializer
//  Description : Pops fifo words and sends them as 8N1 UART frames, LSB first.
//                Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
//  Revision    : 1.0 - initial release
// ============================================================================

module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8
) (
    input  wire logic           clock,
    input  wire logic           reset,
    uart_tx_serializer_if.slave bus
);

    localparam int               BI_W     = $clog2(DATA_BITS) + 1;
    localparam logic [BI_W-1:0]  LAST_BIT = BI_W'(DATA_BITS - 1);

    tx_state_e            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [BI_W-1:0]      r_bit_index;
    logic                 r_tx;
    logic                 r_busy;

    logic                 w_bit_done;
    logic                 w_baud_clear;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_shift_next;

`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock    (clock),
        .reset    (reset),
        .clear    (w_baud_clear),
        .bit_done (w_bit_done)
    );

    // Held at zero while idle so a new frame always starts on a fresh bit period.
    assign w_baud_clear = (r_state == IDLE);

    assign w_pop = ((r_state == IDLE) || ((r_state == STOP) && w_bit_done))
                   && bus.fifo_ready_i && !reset;

    assign w_shift_next = r_shift >> 1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_index <= '0;
            r_tx        <= UART_IDLE_LEVEL;
            r_busy      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state  <= START;
                        r_shift  <= bus.fifo_data_i;
                        r_tx     <= UART_START_LEVEL;
                        r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^bus.fifo_data_i;
`endif
                    end
                end

                START: begin
                    if (w_bit_done) begin
                        r_state     <= DATA;
                        r_bit_index <= '0;
                        r_tx        <= r_shift[0];
                    end
                end

                DATA: begin
                    if (w_bit_done) begin
                        r_shift <= w_shift_next;
                        if (r_bit_index == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= STOP;
                            r_tx    <= UART_IDLE_LEVEL;
`endif
                        end else begin
                            r_bit_index <= r_bit_index + 1'b1;
                            r_tx        <= w_shift_next[0];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_done) begin
                        r_state <= STOP;
                        r_tx    <= UART_IDLE_LEVEL;
                    end
                end
`endif

                STOP: begin
                    if (w_bit_done) begin
                        // Chain straight into the next start bit when data is waiting.
                        if (w_pop) begin
                            r_state  <= START;
                            r_shift  <= bus.fifo_data_i;
                            r_tx     <= UART_START_LEVEL;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^bus.fifo_data_i;
`endif
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= UART_IDLE_LEVEL;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_tx    <= UART_IDLE_LEVEL;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_read_o = w_pop;
    assign bus.tx_o        = r_tx;
    assign bus.busy_o      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_serializer
//  Description : Directed self-checking bench for uart_tx_serializer (CLKS_PER_BIT=4).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_uart_tx_serializer;

    localparam int CPB = 4;
    localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int SLOTS = DB + 3;
`else
    localparam int SLOTS = DB + 2;
`endif
    localparam int FRAME = SLOTS * CPB;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    uart_tx_serializer_if #(.DATA_BITS(DB)) bus ();

    uart_tx_serializer #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int         checks     = 0;
    int         errors     = 0;
    int         cyc        = 0;
    int         underflows = 0;
    logic       ready_en   = 1'b0;
    logic       tx_log   [0:4095];
    logic       busy_log [0:4095];
    logic       rd_log   [0:4095];
    int         pop_cyc  [$];
    logic [7:0] q        [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        bus.fifo_ready_i = ready_en && (q.size() != 0);
        bus.fifo_data_i  = (q.size() != 0) ? q[0] : 8'(cyc * 37);
    endtask

    // One clock: sample the pop request before the edge, log outputs after it.
    task automatic tick();
        logic pre;
        #2;
        pre         = bus.fifo_read_o;
        rd_log[cyc] = pre;
        if (pre) begin
            pop_cyc.push_back(cyc);
            if (!bus.fifo_ready_i) underflows++;
        end
        @(posedge clock);
        #1;
        cyc++;
        if (pre && (q.size() != 0)) void'(q.pop_front());
        drive_inputs();
        tx_log[cyc]   = bus.tx_o;
        busy_log[cyc] = bus.busy_o;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_pops(input int target, input int budget, input string tag);
        int n = 0;
        while ((pop_cyc.size() < target) && (n < budget)) begin
            tick();
            n++;
        end
        chk(tag, pop_cyc.size(), target);
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int i);
        int slot = i / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DB) return b[slot-1];
`ifdef UART_TX_PARITY_EN
        if (slot == DB + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check_frame(input int p, input logic [7:0] b, input string tag);
        int         bad = 0;
        logic [7:0] d;
        for (int i = 0; i < FRAME; i++)
            if (tx_log[p+1+i] !== exp_bit(b, i)) bad++;
        chk({tag, "_bits"}, bad, 0);
        for (int j = 0; j < DB; j++)
            d[j] = tx_log[p + 1 + CPB*(j+1) + CPB/2];
        chk({tag, "_byte"}, d, b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int base;
        int n;
        int bad;

        // Reset with data already waiting: no pop may happen while reset is high.
        ready_en = 1'b1;
        q.push_back(8'd65);
        drive_inputs();
        ticks(3);
        chk("rst_tx", bus.tx_o, 1);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_read", bus.fifo_read_o, 0);
        chk("rst_no_pop", pop_cyc.size(), 0);

        // Single byte 65.
        reset = 1'b0;
        #1;
        chk("idle_pop_req", bus.fifo_read_o, 1);
        wait_pops(1, 5, "single_pop");
        p = pop_cyc[0];
        ticks(FRAME + 5);
        chk("single_pop_count", pop_cyc.size(), 1);
        chk("single_lead_high", tx_log[p], 1);
        check_frame(p, 8'd65, "single");
        n = 0;
        for (int c = p; c <= cyc; c++) if (busy_log[c] === 1'b1) n++;
        chk("single_busy_cycles", n, FRAME);
        chk("single_end_tx", bus.tx_o, 1);
        chk("single_end_busy", bus.busy_o, 0);

        // Empty fifo: everything stays quiet.
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if ((rd_log[cyc-1] !== 1'b0) || (tx_log[cyc] !== 1'b1) || (busy_log[cyc] !== 1'b0)) bad++;
        end
        chk("empty_quiet", bad, 0);

        // Back-to-back stream 65..68.
        base = pop_cyc.size();
        for (int k = 0; k < 4; k++) q.push_back(8'(65 + k));
        drive_inputs();
        wait_pops(base + 4, 4*FRAME + 10, "b2b_pops");
        ticks(FRAME + 5);
        for (int k = 0; k < 4; k++) check_frame(pop_cyc[base+k], 8'(65 + k), "b2b");
        for (int k = 1; k < 4; k++) chk("b2b_spacing", pop_cyc[base+k] - pop_cyc[base+k-1], FRAME);
        n = 0;
        for (int c = pop_cyc[base] + 1; c <= pop_cyc[base+3] + FRAME; c++)
            if (busy_log[c] === 1'b1) n++;
        chk("b2b_busy_cycles", n, 4*FRAME);

        // Reset during data bit 3 of 88.
        base = pop_cyc.size();
        q.push_back(8'd88);
        drive_inputs();
        wait_pops(base + 1, 5, "mid_rst_pop");
        p = pop_cyc[base];
        ticks(p + 1 + CPB*4 + 1 - cyc);
        chk("mid_rst_busy_before", bus.busy_o, 1);
        q.push_back(8'd67);
        reset = 1'b1;
        drive_inputs();
        #1;
        chk("mid_rst_tx", bus.tx_o, 1);
        chk("mid_rst_busy", bus.busy_o, 0);
        chk("mid_rst_read", bus.fifo_read_o, 0);
        ticks(2);
        chk("mid_rst_no_pop", pop_cyc.size(), base + 1);
        chk("mid_rst_fifo_kept", q.size(), 1);
        reset = 1'b0;
        #1;
        wait_pops(base + 2, 5, "post_rst_pop");
        p = pop_cyc[base+1];
        ticks(FRAME + 3);
        check_frame(p, 8'd67, "post_rst");

        // Ready drops during STOP of 69; 70 waits until ready returns.
        base = pop_cyc.size();
        q.push_back(8'd69);
        q.push_back(8'd70);
        drive_inputs();
        wait_pops(base + 1, 5, "drop_pop");
        p = pop_cyc[base];
        ticks(p + 1 + CPB*(SLOTS-1) + 1 - cyc);
        ready_en = 1'b0;
        drive_inputs();
        n = 0;
        while ((bus.busy_o !== 1'b0) && (n < 2*FRAME)) begin
            tick();
            n++;
        end
        chk("drop_idle", bus.busy_o, 0);
        ticks(10);
        chk("drop_no_pop", pop_cyc.size(), base + 1);
        check_frame(p, 8'd69, "drop_first");
        ready_en = 1'b1;
        drive_inputs();
        #1;
        chk("drop_pop_req", bus.fifo_read_o, 1);
        tick();
        chk("drop_pop_count", pop_cyc.size(), base + 2);
        chk("drop_pop_cycle", pop_cyc[base+1], cyc - 1);
        ticks(FRAME + 3);
        check_frame(pop_cyc[base+1], 8'd70, "drop_second");

        chk("no_underflow", underflows, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Downstream consumer of the byte fifo. Pops bytes from the fifo read port and serializes each one onto an asynchronous UART line: 8 data bits, no parity, 1 stop bit, LSB first.
- Feeds the host-link TX pin.
- Purely clocked. Baud timing comes from a cycle divider, not a separate clock.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit period; must be >= 2.
- DATA_BITS, 8, width of the fifo word and of the serialized payload.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_ready_i  input  1  fifo has a valid word on fifo_data_i (fifo read_ready_o).
- fifo_data_i  input  DATA_BITS  head-of-fifo word; valid while fifo_ready_i is high (first-word-fall-through).
- fifo_read_o  output  1  pop strobe to the fifo (fifo read_i); at most one cycle per word.
- tx_o  output  1  serial line; idle high.
- busy_o  output  1  high while a frame is in flight.

Behaviour:
- Interface: one clock `clock`; reset `reset` is asynchronous and active-high.
- Reset values: tx_o=1, fifo_read_o=0, busy_o=0, state=IDLE, counters=0, shift register=0.
- Reset asserted mid-frame: tx_o returns high immediately (asynchronously). The partial byte is discarded. No fifo pop occurs while reset is asserted.
- States: IDLE, START, DATA, STOP.
- fifo_read_o is combinational: (state==IDLE || last cycle of STOP) && fifo_ready_i && !reset.
  - fifo_data_i is captured into the shift register on the same clock edge as the pop.
  - Never pops when fifo_ready_i=0, so the fifo underflow error must never assert.
- IDLE:
  - tx_o=1, busy_o=0.
  - On a pop edge -> START with the baud counter cleared.
- START:
  - tx_o=0 for exactly CLKS_PER_BIT cycles.
  - tx_o falls on the first cycle after the pop cycle (latency 1).
  - Then -> DATA with bit_index=0.
- DATA:
  - tx_o=shift[0] for CLKS_PER_BIT cycles per bit.
  - Shift right at each bit boundary.
  - After bit DATA_BITS-1 -> STOP.
- STOP:
  - tx_o=1 for CLKS_PER_BIT cycles.
  - On the last STOP cycle: if fifo_ready_i, pop and go to START (back-to-back frames, zero gap); else go to IDLE.
- busy_o=1 in START, DATA and STOP.
- Frame length: exactly (DATA_BITS+2)*CLKS_PER_BIT cycles. Continuous streaming has a period of exactly that value.
- Counters:
  - baud counter width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - bit_index width $clog2(DATA_BITS)+1.
  - No other wrap-around cases.
- fifo_data_i changes while not popping: ignored.
- fifo_ready_i drops mid-frame: no effect on the current frame.
- All outputs except fifo_read_o are registered. tx_o is glitch-free.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP.
  - tx_o = even parity (XOR of the DATA_BITS payload bits) for CLKS_PER_BIT cycles.
  - Frame length becomes (DATA_BITS+3)*CLKS_PER_BIT.
- Undefined:
  - No PARITY state and no parity logic.
  - Frame length is (DATA_BITS+2)*CLKS_PER_BIT.

Decomposition:
- Package uart_pkg holds:
  - tx state enum (IDLE, START, DATA, PARITY, STOP);
  - line-level constants UART_IDLE_LEVEL=1, UART_START_LEVEL=0.
- One natural sub-module: uart_baud_counter.
  - Inputs: clock, reset, clear.
  - Output: bit_done, a one-cycle pulse at count CLKS_PER_BIT-1.
  - Shared with a future uart_rx.
- Shift register and FSM stay in the top module.

Test Plan:
- Single byte, CLKS_PER_BIT=4:
  - Stimulus: fifo_ready_i=1 with 8'd65 for one pop.
  - Response: fifo_read_o high exactly 1 cycle; tx_o low 4 cycles starting 1 cycle later.
  - Data bits 1,0,0,0,0,0,1,0 (4 cycles each), then high 4 cycles; busy_o high for 40 cycles.
- Back-to-back, CLKS_PER_BIT=4:
  - Stimulus: fifo holds 65,66,67,68.
  - Response: 4 pops spaced exactly 40 cycles apart; no idle-high gap between stop and next start; decoded bytes 65,66,67,68 in order.
- Empty fifo:
  - Stimulus: fifo_ready_i=0 for 100 cycles.
  - Response: fifo_read_o=0, tx_o=1, busy_o=0 throughout; fifo error_underflow stays 0.
- Reset mid-frame:
  - Stimulus: assert reset during DATA bit 3 of 8'd88.
  - Response: tx_o=1 and busy_o=0 within the same cycle. After release with fifo holding 8'd67, the next frame is a clean, complete 8'd67.
- fifo_ready_i deasserts mid-frame:
  - Stimulus: ready drops during STOP of 8'd69, then rises 10 cycles after IDLE.
  - Response: frame 69 completes; next pop occurs on the first cycle ready=1 while in IDLE.
- UART_TX_PARITY_EN defined:
  - Stimulus: byte 8'd67 (three 1s).
  - Response: parity bit tx_o=1 for 4 cycles between bit 7 and stop; frame 44 cycles.
